// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default depth and the
// Gray/binary conversion helpers used on both clock domains.
package fifo_pkg;

    // Default RAM address width; the FIFO holds 2**DEF_ADDR_SIZE entries.
    localparam int DEF_ADDR_SIZE = 6;

    // Widest pointer the conversion helpers handle.
    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

    // Binary to Gray. Works for any pointer width up to GRAY_MAX_W as long as
    // the caller zero-extends the argument and truncates the result.
    function automatic gray_vec_t bin2gray(input gray_vec_t b);
        return b ^ (b >> 5'd1);
    endfunction

    // Gray to binary. Zero upper bits leave the lower-bit prefix XOR untouched,
    // so the same zero-extend/truncate usage works for any width.
    function automatic gray_vec_t gray2bin(input gray_vec_t g);
        gray_vec_t b;
        b = {GRAY_MAX_W{1'b0}};
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop reset-to-zero synchroniser for a Gray-coded pointer crossing
// into the clk domain. Nothing sits between d and the first flop.
module sync_2ff #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Capture the asynchronous input, then re-time it one more cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer and status controller of the asynchronous FIFO. Runs
// entirely on rclk: synchronises the write Gray pointer, advances the read
// pointer and produces empty, almost-empty and fill level.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                 rclk,
    input  logic                 rrstn,
    input  logic                 r_en,
    input  logic [ADDR_SIZE:0]   wptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_LEVEL);

    logic [PW-1:0] w_syn_wptr;
    logic [PW-1:0] w_wbin;
    logic          w_rd;
    logic [PW-1:0] w_rbinnext;
    logic [PW-1:0] w_rgraynext;
    logic [PW-1:0] w_lvl_next;
    logic          w_rempty_next;
    logic          w_raempty_next;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_rptr;
    logic          r_rempty;
    logic          r_raempty;
    logic [PW-1:0] r_rlevel;

    sync_2ff #(
        .WIDTH (PW)
    ) u_sync_wptr (
        .clk  (rclk),
        .rstn (rrstn),
        .d    (wptr),
        .q    (w_syn_wptr)
    );

    // Next pointer, empty and level; all status reflects the pointer after
    // this cycle's read so empty has no extra-cycle lag.
    always_comb begin
        w_rd           = r_en & ~r_rempty;
        w_rbinnext     = r_bin + {{(PW-1){1'b0}}, w_rd};
        w_rgraynext    = PW'(bin2gray(GRAY_MAX_W'(w_rbinnext)));
        w_wbin         = PW'(gray2bin(GRAY_MAX_W'(w_syn_wptr)));
        // Modular subtraction keeps the level right across pointer wrap.
        w_lvl_next     = w_wbin - w_rbinnext;
        w_rempty_next  = (w_rgraynext == w_syn_wptr);
        w_raempty_next = (w_lvl_next <= AE_LVL);
    end

    // Read pointer and status registers; a read while empty is ignored.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            r_bin     <= {PW{1'b0}};
            r_rptr    <= {PW{1'b0}};
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_rlevel  <= {PW{1'b0}};
        end else begin
            r_bin     <= w_rbinnext;
            r_rptr    <= w_rgraynext;
            r_rempty  <= w_rempty_next;
            r_raempty <= w_raempty_next;
            r_rlevel  <= w_lvl_next;
        end
    end

    assign rempty  = r_rempty;
    assign raempty = r_raempty;
    assign rlevel  = r_rlevel;
    assign raddr   = r_bin[ADDR_SIZE-1:0];
    assign rptr    = r_rptr;

endmodule
